// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: Moore-decoded datapath controls plus a retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN: illegal opcode/funct parks in a sticky TRAP state instead of refetching.
module mips_multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [3:0]       ALUCon,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSource,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retire_count,
   output logic             illegal_op
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
      BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
      TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

`ifdef ILLEGAL_TRAP_EN
   localparam state_t ILLEGAL_NEXT = TRAP;
`else
   localparam state_t ILLEGAL_NEXT = FETCH;
`endif

   state_t     cur, nxt;
   logic       retire;
   logic       funct_ok;
   logic [3:0] funct_alu;

   // The branch decision is taken in the datapath from PCWriteCond and zero.
   logic unused_zero;
   assign unused_zero = zero;

   assign state = cur;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      funct_ok  = 1'b1;
      funct_alu = 4'b0010;
      case (funct)
         6'b100000: funct_alu = 4'b0010;
         6'b100010: funct_alu = 4'b0110;
         6'b100100: funct_alu = 4'b0000;
         6'b100101: funct_alu = 4'b0001;
         6'b101010: funct_alu = 4'b0111;
         6'b100111: funct_alu = 4'b1100;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      nxt    = FETCH;
      retire = 1'b0;
      case (cur)
         FETCH:  nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_R:         nxt = EXEC;
               OP_LW, OP_SW: nxt = MEMADR;
               OP_BEQ:       nxt = BRANCH;
               OP_J:         nxt = JUMP;
               OP_ADDI:      nxt = ADDIEX;
               default:      nxt = ILLEGAL_NEXT;
            endcase
         end
         MEMADR: nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
         MEMWR: begin
            nxt    = mem_ready ? FETCH : MEMWR;
            retire = mem_ready;
         end
         EXEC:   nxt = funct_ok ? ALUWB : ILLEGAL_NEXT;
         ADDIEX: nxt = ADDIWB;
         MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: retire = 1'b1;
`ifdef ILLEGAL_TRAP_EN
         TRAP:   nxt = TRAP;
`endif
         default: nxt = FETCH;
      endcase
   end

   // Moore control decode; only IRWrite/PCWrite in FETCH follow mem_ready.
   always_comb begin
      ALUCon      = 4'b0010;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      case (cur)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         DECODE: ALUSrcB = 2'b11;
         MEMADR, ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUCon  = funct_alu;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUCon      = 4'b0110;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         ADDIWB: RegWrite = 1'b1;
         default: ;
      endcase
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         cur          <= FETCH;
         retire_count <= '0;
      end else begin
         cur <= nxt;
         if (retire) retire_count <= retire_count + CNT_W'(1);
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clock) begin
      if (reset)             illegal_q <= 1'b0;
      else if (nxt == TRAP)  illegal_q <= 1'b1;
   end
   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

endmodule
